// File: rtl/controlador_estabelecidos_pkg.sv
// Shared definitions for the settled-node memory controller: FSM encoding and
// width derivations used by the top and the round-robin arbiter.
package controlador_estabelecidos_pkg;

    localparam logic [1:0] ENC_CLEAR = 2'd0;
    localparam logic [1:0] ENC_IDLE  = 2'd1;
    localparam logic [1:0] ENC_CHECK = 2'd2;

    typedef enum logic [1:0] {
        S_CLEAR = ENC_CLEAR,
        S_IDLE  = ENC_IDLE,
        S_CHECK = ENC_CHECK
    } estado_t;

    // Counters need one extra bit so a full memory (2**ADDR_WIDTH nodes) fits.
    function automatic int cnt_width(input int addr_width);
        return addr_width + 1;
    endfunction

    function automatic int idx_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/controlador_estabelecidos_arbitro.sv
// Combinational round-robin picker: first eligible requester at or after rr_ptr,
// wrapping around. The pointer itself is owned by the parent.
module arbitro_round_robin #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   winner,
    output logic               grant_valid
);

    int j;

    always_comb begin
        grant       = '0;
        winner      = '0;
        grant_valid = 1'b0;
        j           = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // rr_ptr < NUM_REQ, so a single wrap is enough
            j = int'(rr_ptr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!grant_valid && eligible[j]) begin
                grant_valid = 1'b1;
                grant[j]    = 1'b1;
                winner      = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/controlador_estabelecidos.sv
// Write-port arbiter and sequencer for the settled-node memory; filters duplicate
// settles and counts nodes. Define CONTROLADOR_ESTAB_DUP_CNT_EN to build the dup counter.
module controlador_estabelecidos
    import controlador_estabelecidos_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int CNT_WIDTH  = cnt_width(ADDR_WIDTH)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear_in,
    input  logic [CNT_WIDTH-1:0]          num_nodes_in,
    input  logic [NUM_REQ-1:0]            req_in,
    input  logic [ADDR_WIDTH*NUM_REQ-1:0] addr_in,
    output logic [NUM_REQ-1:0]            ack_out,
    output logic                          dup_out,
    output logic                          busy_out,
    output logic                          mem_write_en_out,
    output logic [ADDR_WIDTH-1:0]         mem_write_addr_out,
    output logic                          mem_soft_reset_n_out,
    output logic [ADDR_WIDTH-1:0]         mem_read_addr_out,
    input  logic                          mem_read_data_in,
    output logic [CNT_WIDTH-1:0]          settled_count_out,
    output logic                          all_settled_out,
    output logic [CNT_WIDTH-1:0]          dup_count_out
);

    localparam int IDX_W = idx_width(NUM_REQ);

    estado_t               state;
    logic                  clear_pend;
    logic [IDX_W-1:0]      rr_ptr;
    logic [IDX_W-1:0]      lat_idx;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [CNT_WIDTH-1:0]  settled_cnt;

    logic [NUM_REQ-1:0]    eligible;
    logic [NUM_REQ-1:0]    grant;
    logic [IDX_W-1:0]      winner_idx;
    logic                  grant_valid;
    logic [ADDR_WIDTH-1:0] sel_addr;

    // The requester acked this cycle still has req_in high; keep it out of the race.
    assign eligible = req_in & ~ack_out;

    arbitro_round_robin #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arbitro (
        .eligible    (eligible),
        .rr_ptr      (rr_ptr),
        .grant       (grant),
        .winner      (winner_idx),
        .grant_valid (grant_valid)
    );

    always_comb begin
        sel_addr = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (grant[i]) sel_addr = addr_in[i*ADDR_WIDTH +: ADDR_WIDTH];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= S_CLEAR;
            clear_pend         <= 1'b0;
            rr_ptr             <= '0;
            lat_idx            <= '0;
            lat_addr           <= '0;
            ack_out            <= '0;
            dup_out            <= 1'b0;
            mem_write_en_out   <= 1'b0;
            mem_write_addr_out <= '0;
        end else begin
            ack_out          <= '0;
            dup_out          <= 1'b0;
            mem_write_en_out <= 1'b0;
            case (state)
                S_CLEAR: begin
                    clear_pend <= 1'b0;
                    state      <= S_IDLE;
                end
                S_IDLE: begin
                    if (clear_in || clear_pend) begin
                        state <= S_CLEAR;
                    end else if (grant_valid) begin
                        lat_idx  <= winner_idx;
                        lat_addr <= sel_addr;
                        state    <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    // Finish this grant first; the clear runs from S_IDLE next.
                    if (clear_in) clear_pend <= 1'b1;
                    ack_out <= NUM_REQ'(1) << lat_idx;
                    dup_out <= mem_read_data_in;
                    if (!mem_read_data_in) begin
                        mem_write_en_out   <= 1'b1;
                        mem_write_addr_out <= lat_addr;
                    end
                    rr_ptr <= (lat_idx == IDX_W'(NUM_REQ-1)) ? '0 : lat_idx + IDX_W'(1);
                    state  <= S_IDLE;
                end
                default: state <= S_CLEAR;
            endcase
        end
    end

    // Counts follow the registered ack so they land with the memory write.
    always_ff @(posedge clk) begin
        if (rst || state == S_CLEAR)
            settled_cnt <= '0;
        else if (|ack_out && !dup_out && settled_cnt != {CNT_WIDTH{1'b1}})
            settled_cnt <= settled_cnt + CNT_WIDTH'(1);
    end

`ifdef CONTROLADOR_ESTAB_DUP_CNT_EN
    logic [CNT_WIDTH-1:0] dup_cnt;

    always_ff @(posedge clk) begin
        if (rst || state == S_CLEAR)
            dup_cnt <= '0;
        else if (|ack_out && dup_out && dup_cnt != {CNT_WIDTH{1'b1}})
            dup_cnt <= dup_cnt + CNT_WIDTH'(1);
    end

    assign dup_count_out = dup_cnt;
`else
    assign dup_count_out = '0;
`endif

    assign mem_read_addr_out    = lat_addr;
    assign mem_soft_reset_n_out = (state != S_CLEAR);
    assign busy_out             = (state != S_IDLE) || clear_pend;
    assign settled_count_out    = settled_cnt;
    assign all_settled_out      = (settled_cnt >= num_nodes_in);

endmodule

// File: tb/tb_controlador_estabelecidos.sv
// Bench for controlador_estabelecidos: behavioural memory, directed scenarios
// and a randomized run against a set-based reference model.
module tb_controlador_estabelecidos;

    localparam int AW = 8;
    localparam int NR = 4;
    localparam int CW = AW + 1;
`ifdef CONTROLADOR_ESTAB_DUP_CNT_EN
    localparam bit DUPEN = 1'b1;
`else
    localparam bit DUPEN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clear_in = 1'b0;
    logic [CW-1:0] num_nodes_in = CW'(5);
    logic [NR-1:0] req_in = '0;
    logic [AW*NR-1:0] addr_in = '0;
    logic [NR-1:0] ack_out;
    logic          dup_out, busy_out, mem_write_en_out, mem_soft_reset_n_out;
    logic [AW-1:0] mem_write_addr_out, mem_read_addr_out;
    logic          mem_read_data_in;
    logic [CW-1:0] settled_count_out, dup_count_out;
    logic          all_settled_out;

    logic [(1<<AW)-1:0] mem_bits = '0;
    int checks = 0;
    int failures = 0;

    controlador_estabelecidos #(.ADDR_WIDTH(AW), .NUM_REQ(NR), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .clear_in(clear_in), .num_nodes_in(num_nodes_in),
        .req_in(req_in), .addr_in(addr_in), .ack_out(ack_out), .dup_out(dup_out),
        .busy_out(busy_out), .mem_write_en_out(mem_write_en_out),
        .mem_write_addr_out(mem_write_addr_out), .mem_soft_reset_n_out(mem_soft_reset_n_out),
        .mem_read_addr_out(mem_read_addr_out), .mem_read_data_in(mem_read_data_in),
        .settled_count_out(settled_count_out), .all_settled_out(all_settled_out),
        .dup_count_out(dup_count_out)
    );

    always #5 clk = ~clk;

    // Settled-node memory: soft clear dominates, otherwise one write per cycle.
    always @(posedge clk) begin
        if (!mem_soft_reset_n_out) mem_bits <= '0;
        else if (mem_write_en_out) mem_bits[mem_write_addr_out] <= 1'b1;
    end
    assign mem_read_data_in = mem_bits[mem_read_addr_out];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int i, input int a);
        addr_in[i*AW +: AW] = AW'(a);
    endtask

    task automatic wait_ack(input int max_cyc, output bit got);
        got = 1'b0;
        for (int n = 0; n < max_cyc && !got; n++) begin
            tick();
            if (|ack_out) got = 1'b1;
        end
    endtask

    task automatic do_clear();
        clear_in = 1'b1;
        tick();
        clear_in = 1'b0;
        tick();
    endtask

    function automatic int rr_pick(input logic [NR-1:0] e, input int p);
        for (int k = 0; k < NR; k++)
            if (e[(p + k) % NR]) return (p + k) % NR;
        return -1;
    endfunction

    task automatic test_reset();
        rst = 1'b1; req_in = '0; clear_in = 1'b0; num_nodes_in = CW'(5);
        repeat (3) tick();
        checks++;
        if ({ack_out, dup_out, mem_write_en_out} !== '0) begin
            failures++; $display("FAIL reset_pulses: got %b expected 0", {ack_out, dup_out, mem_write_en_out});
        end
        checks++;
        if (mem_write_addr_out !== '0 || mem_read_addr_out !== '0) begin
            failures++; $display("FAIL reset_addrs: got w=%0d r=%0d expected 0", mem_write_addr_out, mem_read_addr_out);
        end
        checks++;
        if (mem_soft_reset_n_out !== 1'b0 || busy_out !== 1'b1) begin
            failures++; $display("FAIL reset_clear_busy: got soft_n=%b busy=%b expected 0 1", mem_soft_reset_n_out, busy_out);
        end
        checks++;
        if (settled_count_out !== '0 || dup_count_out !== '0 || all_settled_out !== 1'b0) begin
            failures++; $display("FAIL reset_counts: got %0d %0d %b expected 0 0 0", settled_count_out, dup_count_out, all_settled_out);
        end
        rst = 1'b0;
        checks++;
        if (mem_soft_reset_n_out !== 1'b0) begin
            failures++; $display("FAIL clear_after_rst: got %b expected 0", mem_soft_reset_n_out);
        end
        tick();
        checks++;
        if (mem_soft_reset_n_out !== 1'b1 || busy_out !== 1'b0 || settled_count_out !== '0) begin
            failures++; $display("FAIL idle_after_clear: got soft_n=%b busy=%b cnt=%0d expected 1 0 0", mem_soft_reset_n_out, busy_out, settled_count_out);
        end
    endtask

    task automatic test_single();
        req_in = 4'b0001; set_addr(0, 5);
        tick();
        checks++;
        if (ack_out !== '0) begin
            failures++; $display("FAIL single_early_ack: got %b expected 0000", ack_out);
        end
        tick();
        checks++;
        if (ack_out !== 4'b0001 || dup_out !== 1'b0 || mem_write_en_out !== 1'b1 || mem_write_addr_out !== AW'(5)) begin
            failures++; $display("FAIL single_ack: got ack=%b dup=%b we=%b wa=%0d expected 0001 0 1 5", ack_out, dup_out, mem_write_en_out, mem_write_addr_out);
        end
        req_in = '0;
        tick();
        checks++;
        if (settled_count_out !== CW'(1) || ack_out !== '0) begin
            failures++; $display("FAIL single_count: got cnt=%0d ack=%b expected 1 0000", settled_count_out, ack_out);
        end
    endtask

    task automatic test_duplicate();
        bit got;
        do_clear();
        checks++;
        if (settled_count_out !== '0) begin
            failures++; $display("FAIL dup_clear_count: got %0d expected 0", settled_count_out);
        end
        req_in = 4'b0100; set_addr(2, 5);
        wait_ack(6, got);
        checks++;
        if (!got || ack_out !== 4'b0100 || dup_out !== 1'b0 || mem_write_en_out !== 1'b1) begin
            failures++; $display("FAIL dup_first: got ack=%b dup=%b we=%b expected 0100 0 1", ack_out, dup_out, mem_write_en_out);
        end
        req_in = 4'b0010; set_addr(1, 5);
        wait_ack(6, got);
        checks++;
        if (!got || ack_out !== 4'b0010 || dup_out !== 1'b1 || mem_write_en_out !== 1'b0) begin
            failures++; $display("FAIL dup_second: got ack=%b dup=%b we=%b expected 0010 1 0", ack_out, dup_out, mem_write_en_out);
        end
        req_in = '0;
        tick();
        checks++;
        if (settled_count_out !== CW'(1) || dup_count_out !== (DUPEN ? CW'(1) : CW'(0))) begin
            failures++; $display("FAIL dup_counts: got cnt=%0d dups=%0d expected 1 %0d", settled_count_out, dup_count_out, DUPEN ? 1 : 0);
        end
    endtask

    task automatic test_fairness();
        logic [NR-1:0] exp;
        rst = 1'b1; tick(); rst = 1'b0; tick();
        req_in = 4'b1111;
        for (int i = 0; i < NR; i++) set_addr(i, 10 + i);
        for (int t = 1; t <= 8; t++) begin
            tick();
            exp = (t % 2 == 0) ? NR'(1) << (t/2 - 1) : '0;
            checks++;
            if (ack_out !== exp) begin
                failures++; $display("FAIL fair_order t=%0d: got %b expected %b", t, ack_out, exp);
            end
            req_in = req_in & ~ack_out;
        end
        tick();
        checks++;
        if (settled_count_out !== CW'(4)) begin
            failures++; $display("FAIL fair_count: got %0d expected 4", settled_count_out);
        end
    endtask

    task automatic test_completion();
        bit got;
        do_clear();
        num_nodes_in = CW'(3);
        for (int n = 0; n < 3; n++) begin
            req_in = 4'b1000; set_addr(3, 20 + n);
            wait_ack(6, got);
            checks++;
            if (!got || ack_out !== 4'b1000 || all_settled_out !== 1'b0) begin
                failures++; $display("FAIL compl_ack n=%0d: got ack=%b all=%b expected 1000 0", n, ack_out, all_settled_out);
            end
            req_in = '0;
        end
        tick();
        checks++;
        if (all_settled_out !== 1'b1 || settled_count_out !== CW'(3)) begin
            failures++; $display("FAIL compl_rise: got all=%b cnt=%0d expected 1 3", all_settled_out, settled_count_out);
        end
        num_nodes_in = CW'(5);
    endtask

    task automatic test_clear_during_check();
        bit got;
        do_clear();
        req_in = 4'b0001; set_addr(0, 30);
        wait_ack(6, got);
        req_in = '0;
        tick();
        req_in = 4'b0010; set_addr(1, 31);
        tick();
        clear_in = 1'b1;
        tick();
        clear_in = 1'b0;
        checks++;
        if (ack_out !== 4'b0010 || mem_write_en_out !== 1'b1 || busy_out !== 1'b1) begin
            failures++; $display("FAIL clr_pending_ack: got ack=%b we=%b busy=%b expected 0010 1 1", ack_out, mem_write_en_out, busy_out);
        end
        req_in = '0;
        tick();
        checks++;
        if (mem_soft_reset_n_out !== 1'b0) begin
            failures++; $display("FAIL clr_follows: got soft_n=%b expected 0", mem_soft_reset_n_out);
        end
        tick();
        checks++;
        if (settled_count_out !== '0 || mem_soft_reset_n_out !== 1'b1) begin
            failures++; $display("FAIL clr_count: got cnt=%0d soft_n=%b expected 0 1", settled_count_out, mem_soft_reset_n_out);
        end
        req_in = 4'b0001; set_addr(0, 30);
        wait_ack(6, got);
        checks++;
        if (!got || ack_out !== 4'b0001 || dup_out !== 1'b0 || mem_write_en_out !== 1'b1) begin
            failures++; $display("FAIL clr_rewrite: got ack=%b dup=%b we=%b expected 0001 0 1", ack_out, dup_out, mem_write_en_out);
        end
        req_in = '0;
        tick();
    endtask

    task automatic test_random();
        logic [NR-1:0]      pending = '0;
        int                 paddr [NR];
        logic [NR-1:0]      elig_hist [0:1023];
        bit [(1<<AW)-1:0]   ref_set = '0;
        int ref_cnt = 0, ref_dup = 0, ref_ptr = 0;
        int exp_ack_at = -1, next_idle = 0, w, a;
        bit exp_dup;
        rst = 1'b1; tick(); rst = 1'b0; tick();
        num_nodes_in = CW'(12);
        for (int i = 0; i < NR; i++) paddr[i] = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            checks++;
            if (settled_count_out !== CW'(ref_cnt) || all_settled_out !== (ref_cnt >= 12)) begin
                failures++; $display("FAIL rnd_count cyc=%0d: got %0d/%b expected %0d", cyc, settled_count_out, all_settled_out, ref_cnt);
            end
            checks++;
            if (dup_count_out !== (DUPEN ? CW'(ref_dup) : CW'(0))) begin
                failures++; $display("FAIL rnd_dupcnt cyc=%0d: got %0d expected %0d", cyc, dup_count_out, DUPEN ? ref_dup : 0);
            end
            if (cyc == exp_ack_at) begin
                w = rr_pick(elig_hist[cyc-2], ref_ptr);
                a = paddr[w];
                exp_dup = ref_set[a];
                checks++;
                if (ack_out !== NR'(1) << w || dup_out !== exp_dup || mem_write_en_out !== !exp_dup ||
                    (!exp_dup && mem_write_addr_out !== AW'(a))) begin
                    failures++; $display("FAIL rnd_ack cyc=%0d: got ack=%b dup=%b we=%b wa=%0d expected req %0d dup=%b addr %0d",
                                         cyc, ack_out, dup_out, mem_write_en_out, mem_write_addr_out, w, exp_dup, a);
                end
                if (exp_dup) ref_dup++; else ref_cnt++;
                ref_set[a] = 1'b1;
                ref_ptr = (w + 1) % NR;
                pending[w] = 1'b0;
            end else begin
                checks++;
                if (ack_out !== '0 || mem_write_en_out !== 1'b0) begin
                    failures++; $display("FAIL rnd_spurious cyc=%0d: got ack=%b we=%b expected 0000 0", cyc, ack_out, mem_write_en_out);
                end
            end
            for (int i = 0; i < NR; i++) begin
                if (cyc < 500 && !pending[i] && $urandom_range(0, 3) == 0) begin
                    pending[i] = 1'b1;
                    paddr[i] = int'($urandom_range(0, 15));
                end
                set_addr(i, paddr[i]);
            end
            req_in = pending;
            elig_hist[cyc] = req_in & ~ack_out;
            if (cyc >= next_idle && elig_hist[cyc] != '0) begin
                exp_ack_at = cyc + 2;
                next_idle = cyc + 2;
            end
            tick();
        end
        checks++;
        if (pending !== '0) begin
            failures++; $display("FAIL rnd_drain: got pending=%b expected 0000", pending);
        end
        req_in = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_duplicate();
        test_fairness();
        test_completion();
        test_clear_during_check();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/controlador_estabelecidos.md
# controlador_estabelecidos

Sequencer and write-port arbiter for the settled-node memory of the shortest-path engine. Shares the memory's single write port among NUM_REQ requesters in round-robin order, checks each request against the memory through one read port so duplicates are rejected, and keeps a running count of settled nodes. Also owns the memory's soft clear: it issues the clear after reset and on command, so the memory and the count always agree.

## Interface
- ADDR_WIDTH, 8, node address width; the memory has 2**ADDR_WIDTH entries
- NUM_REQ, 4, number of requesters; must be at least 2
- CNT_WIDTH, ADDR_WIDTH+1, width of the counters and of num_nodes_in

- clk  in  1  sole clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- clear_in  in  1  pulse; clear the memory and the count
- num_nodes_in  in  CNT_WIDTH  node count of the current graph
- req_in  in  NUM_REQ  per-requester write request; held until acked
- addr_in  in  ADDR_WIDTH*NUM_REQ  packed node addresses; requester i uses bits [ADDR_WIDTH*i +: ADDR_WIDTH]
- ack_out  out  NUM_REQ  one-cycle, one-hot completion pulse
- dup_out  out  1  valid with ack_out; 1 means the node was already settled and was not written
- busy_out  out  1  high when not in S_IDLE or when a clear is pending
- mem_write_en_out  out  1  memory write enable
- mem_write_addr_out  out  ADDR_WIDTH  memory write address
- mem_soft_reset_n_out  out  1  memory soft clear, active low
- mem_read_addr_out  out  ADDR_WIDTH  memory read address
- mem_read_data_in  in  1  combinational read data for mem_read_addr_out
- settled_count_out  out  CNT_WIDTH  number of distinct nodes settled since the last clear
- all_settled_out  out  1  settled_count_out >= num_nodes_in
- dup_count_out  out  CNT_WIDTH  duplicate-rejection count (see Configuration)

## Operation
- States: S_CLEAR, S_IDLE, S_CHECK. Reset forces S_CLEAR.
- S_CLEAR
  - mem_soft_reset_n_out is 0, combinationally from the state.
  - The settled count, the dup count and clear_pend are zeroed.
  - Goes to S_IDLE after 1 cycle.
- S_IDLE
  - clear_in or clear_pend: go to S_CLEAR. Clear has priority over requests.
  - Otherwise build the eligible set: req_in with the current ack_out bits masked off.
  - If the set is non-empty, pick a winner round-robin starting at pointer rr_ptr. Latch the winner's index and address, then go to S_CHECK.
- S_CHECK
  - mem_read_addr_out carries the latched address.
  - If clear_in arrives during S_CHECK, set clear_pend.
  - Sample mem_read_data_in:
    - 0: next cycle, mem_write_en_out=1, mem_write_addr_out=the address, ack to the winner with dup_out=0; settled count +1.
    - 1: next cycle, ack to the winner with dup_out=1 and no write; dup count +1.
  - rr_ptr becomes (winner+1) mod NUM_REQ. Go to S_IDLE.
- Both counters saturate at 2**CNT_WIDTH-1.
- mem_read_addr_out holds its last value outside S_CHECK.

## Timing
- Reset values:
  - ack_out=0, dup_out=0, mem_write_en_out=0, mem_write_addr_out=0.
  - mem_soft_reset_n_out=0, because the state is S_CLEAR.
  - mem_read_addr_out=0, counts=0, all_settled_out=(0>=num_nodes_in), busy_out=1, rr_ptr=0.
- Request first seen in S_IDLE at cycle T:
  - S_CHECK at T+1.
  - ack_out, dup_out and mem_write_en_out are registered and visible at T+2.
  - The memory is updated at the end of T+2.
  - Throughput is one request per 2 cycles.
- A request for the same node can reach S_CHECK no earlier than T+3, so it always reads the updated bit. There is no read-after-write hazard.
- A requester may drop req_in or change addr_in only in the cycle its ack is high. Masking the acked requester in S_IDLE prevents it from being granted twice.
- rst mid-operation:
  - An in-flight grant is dropped with no ack.
  - The FSM re-clears the memory, so a requester must re-issue its request.

## Configuration
- CONTROLADOR_ESTAB_DUP_CNT_EN defined: dup_count_out carries the saturating duplicate counter.
- Not defined: the counter is not built and dup_count_out is tied to 0. dup_out and the duplicate filtering are unchanged.

## Structure
- Shared package:
  - state encoding localparams S_CLEAR/S_IDLE/S_CHECK
  - CNT_WIDTH derivation
- Sub-module arbitro_round_robin:
  - inputs: eligible vector and rr_ptr
  - outputs: one-hot grant and winner index, combinational
  - rr_ptr stays in the parent.

## Test plan
- Reset then idle: mem_soft_reset_n_out=0 for exactly 1 cycle after rst drops, then 1; settled_count_out=0.
- Single request: req_in[0] with addr 5 at T -> ack_out=0001, dup_out=0, write of addr 5 at T+2; count=1.
- Duplicate: requester 2 writes 5, then requester 1 writes 5 -> second ack has dup_out=1 and no write; count stays 1; dup_count_out=1 with the macro, 0 without.
- Fairness: all 4 requesters hold req_in with addrs 10..13 from rr_ptr=0 -> acks in order 0,1,2,3 at 2-cycle spacing; count=4.
- Completion: num_nodes_in=3, settle 3 distinct nodes -> all_settled_out rises in the cycle after the third ack.
- Clear during S_CHECK: the pending ack still completes, then S_CLEAR follows -> count=0, and the previously settled node rewritten afterwards returns dup_out=0.
